// File: rtl/wide_addsub_seq.sv
// Iterative DATA_LEN-bit add/subtract built on one SLICE_LEN-bit adder slice.
// The carry between slices is held in a register, and the LSB slice is processed first.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an operation, in_ready=1
//   RUN   | one slice per cycle, idx selects the slice, carry chains
//   DONE  | result held with out_valid=1 until out_ready
module wide_addsub_seq #(
  parameter int DATA_LEN  = 64,
  parameter int SLICE_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] op_a,
  input  logic [DATA_LEN-1:0] op_b,
  input  logic                sub,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] sum,
  output logic                cout,
  output logic                overflow,
  output logic                busy
);

  localparam int NSLICE = DATA_LEN / SLICE_LEN;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Operands are stored sliced, so idx can pick out one adder slice directly.
  logic [NSLICE-1:0][SLICE_LEN-1:0] a_q, b_q, sum_q;
  logic [IDX_W-1:0]                 idx;
  logic                             carry;
  logic                             cout_q;
  logic                             ovf_q;
  logic [SLICE_LEN:0]               slice_res;
  logic                             accept;
  logic                             last_slice;

  assign accept     = in_valid && (state == IDLE) && !flush;
  assign last_slice = (state == RUN) && (idx == LAST_IDX);
  assign slice_res  = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {{SLICE_LEN{1'b0}}, carry};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)         state_nxt = RUN;
      RUN:     if (idx == LAST_IDX)  state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      idx <= '0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: B is inverted once here and the +1 seeds the carry.
      a_q   <= op_a;
      b_q   <= op_b ^ {DATA_LEN{sub}};
      carry <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= slice_res[SLICE_LEN-1:0];
      carry      <= slice_res[SLICE_LEN];
      idx        <= idx + 1'b1;
      if (last_slice) begin
        idx    <= '0;
        cout_q <= slice_res[SLICE_LEN];
        ovf_q  <= (a_q[NSLICE-1][SLICE_LEN-1] == b_q[NSLICE-1][SLICE_LEN-1]) &&
                  (a_q[NSLICE-1][SLICE_LEN-1] != slice_res[SLICE_LEN-1]);
      end
    end
  end

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Directed and random checks of wide_addsub_seq (64-bit, 16-bit slices), compared against
// a signed/unsigned arithmetic reference.
module tb_wide_addsub_seq;

  localparam int DATA_LEN  = 64;
  localparam int SLICE_LEN = 16;
  localparam int NSLICE    = DATA_LEN / SLICE_LEN;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_LEN-1:0] op_a = '0;
  logic [DATA_LEN-1:0] op_b = '0;
  logic                sub = 1'b0;
  logic                flush = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_LEN-1:0] sum;
  logic                cout;
  logic                overflow;
  logic                busy;

  int checks = 0;
  int errors = 0;

  wide_addsub_seq #(.DATA_LEN(DATA_LEN), .SLICE_LEN(SLICE_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: true signed and unsigned arithmetic, no slicing.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] r, output logic c, output logic v);
    logic signed [65:0] sa, sb, sr;
    logic        [64:0] ua, ub, ur;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    sr = s ? (sa - sb) : (sa + sb);
    ua = {1'b0, a};
    ub = {1'b0, b};
    ur = ua + ub;
    r  = sr[63:0];
    c  = s ? (a >= b) : ur[64];
    v  = (sr > 66'sd9223372036854775807) || (sr < -66'sd9223372036854775808);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic s);
    logic [63:0] er;
    logic        ec, ev;
    int          n;
    model(a, b, s, er, ec, ev);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, n);
    chk({tag, "_lat"}, 64'(n), 64'(NSLICE));
    chk({tag, "_sum"}, sum, er);
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(ev));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] er, er2, hold_sum;
    logic        ec, ev, ec2, ev2;
    int          n;

    #2;
    chk("rst_sum", sum, 64'd0);
    chk("rst_flags", {61'd0, cout, overflow, out_valid}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;
    tick();

    do_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    do_op("sub_0m1", 64'd0, 64'd1, 1'b1);
    do_op("sub_borrow", 64'h0001_0000_0000_0000, 64'd1, 1'b1);
    do_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    do_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1);

    // Backpressure: result must hold while a competing request is ignored.
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, er, ec, ev);
    model(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, er2, ec2, ev2);
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("bp", n);
    op_a = 64'h5; op_b = 64'h7; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_sum_hold", sum, er);
      chk("bp_flags_hold", {61'd0, cout, overflow, out_valid}, {61'd0, ec, ev, 1'b1});
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_retire", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_acc", 64'(busy), 64'd1);
    wait_done("bp2", n);
    chk("bp2_sum", sum, er2);
    chk("bp2_cout", 64'(cout), 64'(ec2));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush mid-run, at slice index 2.
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("flush_no_valid", 64'(n), 64'd0);
    do_op("after_flush", 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0);

    // Asynchronous reset while running.
    op_a = 64'hAAAA_5555_AAAA_5555; op_b = 64'h1111_2222_3333_4444; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", sum, 64'd0);
    chk("arst_flags", {61'd0, cout, overflow, out_valid}, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #2 rst_n = 1'b1;
    do_op("post_rst", 64'd1, 64'd2, 1'b0);
    chk("post_rst_3", sum, 64'd3);

    for (int i = 0; i < 20; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 5 == 0) rb = ra;
      do_op("rand", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
